// File: rtl/stats_log_wr_arbiter.sv
// Round-robin arbiter sharing one log write port between NUM_SRCS stats recorders.
// Each source has a 1-entry holding register; overflow is counted rather than back-pressured.
module stats_log_wr_arbiter #(
    parameter int NUM_SRCS   = 4,
    parameter int SRC_ID_W   = $clog2(NUM_SRCS),
    parameter int DATA_W     = 64,
    parameter int DROP_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRCS-1:0]          src_wr_val,
    input  logic [NUM_SRCS*DATA_W-1:0]   src_wr_data,
    input  logic                         log_freeze,
    input  logic                         clear_drops,
    output logic                         log_wr_req_val,
    output logic [SRC_ID_W+DATA_W-1:0]   log_wr_req_data,
    output logic [NUM_SRCS-1:0]          pend_vec,
    output logic [NUM_SRCS-1:0]          src_overflow,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);

    localparam int CNT_EXT_W = DROP_CNT_W + SRC_ID_W + 1;

    logic [DATA_W-1:0]          hold_q [NUM_SRCS];
    logic [DATA_W-1:0]          hold_d [NUM_SRCS];
    logic [NUM_SRCS-1:0]        pend_q, pend_d;
    logic [NUM_SRCS-1:0]        ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0]      drop_q, drop_d;
    logic [SRC_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                       wr_val_q, wr_val_d;
    logic [SRC_ID_W+DATA_W-1:0] wr_data_q, wr_data_d;

    logic                       grant_any;
    logic [SRC_ID_W-1:0]        grant_idx;
    logic [NUM_SRCS-1:0]        grant_vec;
    logic [SRC_ID_W:0]          cand;
    logic [NUM_SRCS-1:0]        capture;
    logic [NUM_SRCS-1:0]        drop;
    logic [CNT_EXT_W-1:0]       drop_sum;

    // Scan from the far end back towards rr_ptr so the last hit is the first in search order.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        cand      = '0;
        if (!log_freeze) begin
            for (int k = NUM_SRCS - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + (SRC_ID_W+1)'(k);
                if (cand >= (SRC_ID_W+1)'(NUM_SRCS)) begin
                    cand = cand - (SRC_ID_W+1)'(NUM_SRCS);
                end
                if (pend_q[cand[SRC_ID_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[SRC_ID_W-1:0];
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // A granted entry frees its slot on this edge, so a same-cycle strobe refills it without a drop.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRCS; gi++) begin : g_src
            always_comb begin
                capture[gi] = src_wr_val[gi] && (!pend_q[gi] || grant_vec[gi]);
                drop[gi]    = src_wr_val[gi] && pend_q[gi] && !grant_vec[gi];
                hold_d[gi]  = capture[gi] ? src_wr_data[gi*DATA_W +: DATA_W] : hold_q[gi];
                if (capture[gi]) begin
                    pend_d[gi] = 1'b1;
                end else if (grant_vec[gi]) begin
                    pend_d[gi] = 1'b0;
                end else begin
                    pend_d[gi] = pend_q[gi];
                end
            end

            always_ff @(posedge clk) begin
                hold_q[gi] <= hold_d[gi];
            end
        end
    endgenerate

    always_comb begin
        ovf_d    = (clear_drops ? '0 : ovf_q) | drop;
        drop_sum = clear_drops ? '0 : CNT_EXT_W'(drop_q);
        for (int i = 0; i < NUM_SRCS; i++) begin
            drop_sum = drop_sum + CNT_EXT_W'(drop[i]);
        end
        if (drop_sum > CNT_EXT_W'({DROP_CNT_W{1'b1}})) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_comb begin
        wr_val_d  = grant_any;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant_any) begin
            wr_data_d = {grant_idx, hold_q[grant_idx]};
            if (grant_idx == SRC_ID_W'(NUM_SRCS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + SRC_ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= '0;
            ovf_q     <= '0;
            drop_q    <= '0;
            rr_ptr_q  <= '0;
            wr_val_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_val_q  <= wr_val_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign log_wr_req_val  = wr_val_q;
    assign log_wr_req_data = wr_data_q;
    assign pend_vec        = pend_q;
    assign src_overflow    = ovf_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_stats_log_wr_arbiter.sv
// Directed scoreboard bench for stats_log_wr_arbiter: expected writes are queued by the
// stimulus, and a negedge monitor pops and compares every log write the DUT issues.
module tb_stats_log_wr_arbiter;

    localparam int NUM_SRCS   = 4;
    localparam int SRC_ID_W   = 2;
    localparam int DATA_W     = 64;
    localparam int DROP_CNT_W = 16;
    localparam int WR_W       = SRC_ID_W + DATA_W;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [NUM_SRCS-1:0]        src_wr_val = '0;
    logic [NUM_SRCS*DATA_W-1:0] src_wr_data = '0;
    logic                       log_freeze = 1'b0;
    logic                       clear_drops = 1'b0;
    logic                       log_wr_req_val;
    logic [WR_W-1:0]            log_wr_req_data;
    logic [NUM_SRCS-1:0]        pend_vec;
    logic [NUM_SRCS-1:0]        src_overflow;
    logic [DROP_CNT_W-1:0]      drop_cnt;

    int checks = 0;
    int passed = 0;
    logic [WR_W-1:0] exp_q [$];
    logic            mon_en = 1'b0;

    stats_log_wr_arbiter #(
        .NUM_SRCS(NUM_SRCS), .SRC_ID_W(SRC_ID_W), .DATA_W(DATA_W), .DROP_CNT_W(DROP_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .src_wr_val(src_wr_val), .src_wr_data(src_wr_data),
        .log_freeze(log_freeze), .clear_drops(clear_drops),
        .log_wr_req_val(log_wr_req_val), .log_wr_req_data(log_wr_req_data),
        .pend_vec(pend_vec), .src_overflow(src_overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WR_W-1:0] act, input logic [WR_W-1:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
            $display("check %-22s ok   act=%0h", name, act);
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every issued write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && log_wr_req_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: actual=%0h required=none", log_wr_req_data);
            end else begin
                check("log_write", log_wr_req_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int src, input logic [DATA_W-1:0] d);
        src_wr_data[src*DATA_W +: DATA_W] = d;
    endtask

    task automatic strobe(input logic [NUM_SRCS-1:0] v);
        src_wr_val = v;
        step();
        src_wr_val = '0;
    endtask

    task automatic expect_wr(input int src, input logic [DATA_W-1:0] d);
        logic [SRC_ID_W-1:0] id;
        id = SRC_ID_W'(src);
        exp_q.push_back({id, d});
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_val", WR_W'(log_wr_req_val), '0);
        check("rst_data", log_wr_req_data, '0);
        check("rst_pend", WR_W'(pend_vec), '0);
        check("rst_drop", WR_W'(drop_cnt), '0);
        step();
        rst = 1'b1;
        mon_en = 1'b1;
        step();

        // Single-source latency: write registered on the second edge after the strobe
        put(0, 64'hA5);
        expect_wr(0, 64'hA5);
        strobe(4'b0001);
        check("lat_not_early", WR_W'(log_wr_req_val), '0);
        step();
        check("lat_val_cycle2", WR_W'(log_wr_req_val), 1);
        check("lat_pend_clear", WR_W'(pend_vec), '0);

        // Move rr_ptr to 2 via a source-1 write
        put(1, 64'hB1);
        expect_wr(1, 64'hB1);
        strobe(4'b0010);
        repeat (3) step();

        // Round-robin: all four strobe with rr_ptr=2 -> order 2,3,0,1
        for (int i = 0; i < NUM_SRCS; i++) put(i, 64'hC0 + 64'(i));
        expect_wr(2, 64'hC2);
        expect_wr(3, 64'hC3);
        expect_wr(0, 64'hC0);
        expect_wr(1, 64'hC1);
        strobe(4'b1111);
        repeat (6) step();
        check("rr_pend_drained", WR_W'(pend_vec), '0);

        // rr_ptr should be back at 2: sources 1 and 2 together -> 2 first
        put(1, 64'hD1);
        put(2, 64'hD2);
        expect_wr(2, 64'hD2);
        expect_wr(1, 64'hD1);
        strobe(4'b0110);
        repeat (4) step();

        // Back-to-back single source, 10 records
        for (int i = 0; i < 10; i++) begin
            put(1, 64'h100 + 64'(i));
            expect_wr(1, 64'h100 + 64'(i));
            strobe(4'b0010);
        end
        repeat (4) step();
        check("b2b_drop_zero", WR_W'(drop_cnt), '0);
        check("b2b_ovf_zero", WR_W'(src_overflow), '0);

        // Overflow under freeze: oldest record kept, two drops
        log_freeze = 1'b1;
        put(3, 64'h11); strobe(4'b1000);
        put(3, 64'h22); strobe(4'b1000);
        put(3, 64'h33); strobe(4'b1000);
        step();
        check("ovf_flags", WR_W'(src_overflow), 4'b1000);
        check("ovf_drop_cnt", WR_W'(drop_cnt), 2);
        check("ovf_pend_held", WR_W'(pend_vec), 4'b1000);
        expect_wr(3, 64'h11);
        log_freeze = 1'b0;
        repeat (4) step();
        check("ovf_pend_drained", WR_W'(pend_vec), '0);

        // Clear with no drops
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;
        check("clear_drop_cnt", WR_W'(drop_cnt), '0);
        check("clear_ovf", WR_W'(src_overflow), '0);

        // Saturation: fill all four, then 16383 x 4 drops + 2 drops = 0xFFFE
        log_freeze = 1'b1;
        for (int i = 0; i < 16384; i++) strobe(4'b1111);
        strobe(4'b0011);
        check("sat_pre", WR_W'(drop_cnt), 16'hFFFE);
        strobe(4'b0111);
        check("sat_ffff", WR_W'(drop_cnt), 16'hFFFF);
        clear_drops = 1'b1;
        strobe(4'b0101);
        clear_drops = 1'b0;
        check("clear_with_drops", WR_W'(drop_cnt), 2);
        check("clear_ovf_bits", WR_W'(src_overflow), 4'b0101);
        check("sat_pend_full", WR_W'(pend_vec), 4'b1111);

        // Asynchronous reset mid-cycle with all entries pending
        #2;
        rst = 1'b0;
        #1;
        check("arst_pend", WR_W'(pend_vec), '0);
        check("arst_val", WR_W'(log_wr_req_val), '0);
        check("arst_drop", WR_W'(drop_cnt), '0);
        check("arst_ovf", WR_W'(src_overflow), '0);
        log_freeze = 1'b0;
        #4;
        rst = 1'b1;
        repeat (6) step();
        check("post_rst_pend", WR_W'(pend_vec), '0);

        check("scoreboard_empty", WR_W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stats_log_wr_arbiter.md
Name: stats_log_wr_arbiter

Overview:
- Shares the single write port of one simple_log stats memory between NUM_SRCS independent stats recorders, e.g. several rs_encode_stats_record instances in one tile.
- Each source gets a 1-entry holding register.
- Round-robin arbitration grants one registered log write per cycle, tagged with the source ID.
- A freeze input lets the NoC log reader stall writes while it drains the log. Overflow is counted, not back-pressured, because recorders have no ready.

Parameters:
- NUM_SRCS, 4, number of recorder sources (>=2).
- SRC_ID_W, $clog2(NUM_SRCS), derived width of the source tag.
- DATA_W, 64, width of one recorder stats struct.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- src_wr_val  in  NUM_SRCS  per-source write strobe; bit i belongs to source i.
- src_wr_data  in  NUM_SRCS*DATA_W  per-source record; source i occupies bits [i*DATA_W +: DATA_W].
- log_freeze  in  1  level; while high, no log writes are issued.
- clear_drops  in  1  pulse; zeroes drop_cnt and src_overflow.
- log_wr_req_val  out  1  write strobe to simple_log.
- log_wr_req_data  out  SRC_ID_W+DATA_W  {src_id, record}.
- pend_vec  out  NUM_SRCS  holding-register occupied flags.
- src_overflow  out  NUM_SRCS  sticky per-source drop flags.
- drop_cnt  out  DROP_CNT_W  saturating total drop count.

Behaviour:
- Reset (rst low, asynchronous) clears: log_wr_req_val=0, log_wr_req_data=0, pend_vec=0, src_overflow=0, drop_cnt=0, rr_ptr=0. Holding-register data is don't-care.
- Holding register i captures src_wr_data on src_wr_val[i]. pend[i] sets on the next edge.
- Arbitration is combinational over pend_vec when log_freeze=0:
  - Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_SRCS.
  - The first pending source g wins.
- Write issue on the edge after arbitration:
  - log_wr_req_val=1 and log_wr_req_data={g, hold[g]}.
  - pend[g] clears, unless it is re-filled on the same edge.
  - rr_ptr = (g+1) mod NUM_SRCS; wrap at NUM_SRCS-1 goes to 0.
- With no grant, log_wr_req_val=0, data holds its last value, and rr_ptr is unchanged.
- Latency: src_wr_val at edge N gives, with no contention and no freeze, log_wr_req_val high on the cycle after edge N+1. Minimum 2 cycles from strobe to write.
- Throughput: 1 write per cycle total; an uncontended source can write every cycle (capture and drain overlap).
- Simultaneous grant and new strobe on the same source: the old entry is written and the new data is captured. pend stays 1 with no drop.
- Strobe while pend[i]=1 and source i not granted this cycle:
  - The new record is discarded and the held (older) record is kept.
  - src_overflow[i] sets and drop_cnt increments.
- Multiple sources dropping in the same cycle: drop_cnt adds popcount of the dropping sources, saturating at all-ones with no wrap.
- clear_drops in the same cycle as drops: the clear applies first, then this cycle's drops are added, so the result equals this cycle's popcount. src_overflow bits for this cycle's drops end set.
- log_freeze high:
  - No grants; rr_ptr frozen; captures continue; drop rules apply.
  - A freeze asserted in the same cycle a grant would be computed blocks that grant. A write already registered still completes.
  - On deassert, arbitration resumes from the frozen rr_ptr the same cycle.
- No combinational path from inputs to outputs; all outputs are registered.
- Mid-operation reset discards all pending entries without issuing writes. No write strobe appears during or on the first cycle after reset release.

Test Plan:
- Single-source latency: src_wr_val=0001, data 0xA5 at cycle 0 -> log_wr_req_val=1 at cycle 2 with data {2'd0, 0xA5}; pend_vec returns to 0000.
- Round-robin fairness: all four sources strobe once at cycle 0 with rr_ptr=2 -> writes in order src 2,3,0,1 on cycles 2-5; rr_ptr ends at 2.
- Back-to-back single source: src 1 strobes every cycle for 10 cycles with no contention -> 10 writes, drop_cnt=0, data in order.
- Overflow: freeze high; src 3 strobes 0x11 then 0x22 then 0x33 -> src_overflow=1000, drop_cnt=2; after unfreeze exactly one write {2'd3, 0x11}.
- Saturation and clear: force drop_cnt to 0xFFFE, then 3 drops in one cycle -> 0xFFFF. Then clear_drops together with 2 drops -> drop_cnt=2.
- Async reset mid-stream: pend_vec=1111, rst low for half a cycle -> outputs zero immediately; no writes after release without new strobes.
